apu_frame_sequencer: RTL and testbench



---
 rtl/apu_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_apu_frame_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: quarter/half-frame clocks and frame IRQ for 4-step and 5-step
// sequences, with parity-delayed sequencer reset and 5-step entry burst on control writes.
module apu_frame_sequencer #(
  parameter int CNT_W     = 16,
  parameter int STEP1     = 7457,
  parameter int STEP2     = 14913,
  parameter int STEP3     = 22371,
  parameter int STEP4_END = 29829,
  parameter int STEP5_END = 37281,
  parameter int DLY_EVEN  = 3,
  parameter int DLY_ODD   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_en,
  input  logic       write_ctrl,
  input  logic [1:0] ctrl_wdata,
  input  logic       read_status,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       irq,
  output logic [2:0] step,
  output logic       reset_pending
);

  localparam logic [CNT_W-1:0] P1   = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] P2   = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] P3   = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] P4E  = CNT_W'(STEP4_END);
  localparam logic [CNT_W-1:0] P4M1 = CNT_W'(STEP4_END - 1);
  localparam logic [CNT_W-1:0] P5E  = CNT_W'(STEP5_END);
  localparam logic [2:0]       D_EVEN = 3'(DLY_EVEN);
  localparam logic [2:0]       D_ODD  = 3'(DLY_ODD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] end_cnt;
  logic             mode;
  logic             inhibit;
  logic             irq_flg;
  logic             cpu_odd;
  logic             pend_mode5;
  logic             wrapped;
  logic [2:0]       dly;

  logic at_end;
  logic dly_hit;
  logic burst;
  logic wr;
  logic irq_set;
  logic irq_clr;

  assign end_cnt = mode ? P5E : P4E;
  assign at_end  = (cnt == end_cnt);
  assign dly_hit = (dly == 3'd1);
  // The 5-step entry burst fires on the same strobe that zeroes the counter.
  assign burst   = dly_hit & pend_mode5;
  assign wr      = cpu_en & write_ctrl;

  assign quarter_frame = cpu_en & (burst | (cnt == P1) | (cnt == P2) | (cnt == P3) | at_end);
  assign half_frame    = cpu_en & (burst | (cnt == P2) | at_end);

  assign irq_set = ~mode & ~inhibit &
                   ((cnt == P4M1) | (cnt == P4E) | ((cnt == '0) & wrapped));
  assign irq_clr = inhibit | (cpu_en & read_status) | (wr & ctrl_wdata[0]);

  assign irq           = irq_flg;
  assign reset_pending = (dly != 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      wrapped <= 1'b0;
      step    <= 3'd0;
    end else if (cpu_en) begin
      if (dly_hit) begin
        cnt     <= '0;
        wrapped <= 1'b0;
        step    <= 3'd0;
      end else if (at_end) begin
        cnt     <= '0;
        wrapped <= 1'b1;
        step    <= 3'd0;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        wrapped <= 1'b0;
        if (cnt == P1)               step <= 3'd1;
        else if (cnt == P2)          step <= 3'd2;
        else if (cnt == P3)          step <= 3'd3;
        else if (mode && cnt == P4E) step <= 3'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode       <= 1'b0;
      inhibit    <= 1'b0;
      cpu_odd    <= 1'b0;
      dly        <= 3'd0;
      pend_mode5 <= 1'b0;
    end else if (cpu_en) begin
      cpu_odd <= ~cpu_odd;
      if (write_ctrl) begin
        mode       <= ctrl_wdata[1];
        inhibit    <= ctrl_wdata[0];
        pend_mode5 <= ctrl_wdata[1];
        dly        <= cpu_odd ? D_ODD : D_EVEN;
      end else if (dly != 3'd0) begin
        dly <= dly - 3'd1;
      end
    end
  end

  // Clear wins over set so a read or inhibit write on a set cycle leaves the flag low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_flg <= 1'b0;
    end else if (irq_clr) begin
      irq_flg <= 1'b0;
    end else if (cpu_en && irq_set) begin
      irq_flg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer: a frame-level reference model queues the
// expected outputs per clock and a negedge monitor compares them against the DUT.
module tb_apu_frame_sequencer;

  localparam int CNT_W = 8;
  localparam int S1    = 37;
  localparam int S2    = 74;
  localparam int S3    = 111;
  localparam int S4E   = 149;
  localparam int S5E   = 186;
  localparam int DE    = 3;
  localparam int DO    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_en = 1'b0;
  logic       write_ctrl = 1'b0;
  logic [1:0] ctrl_wdata = 2'b00;
  logic       read_status = 1'b0;
  logic       quarter_frame;
  logic       half_frame;
  logic       irq;
  logic [2:0] step;
  logic       reset_pending;

  apu_frame_sequencer #(
    .CNT_W(CNT_W), .STEP1(S1), .STEP2(S2), .STEP3(S3),
    .STEP4_END(S4E), .STEP5_END(S5E), .DLY_EVEN(DE), .DLY_ODD(DO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .write_ctrl(write_ctrl),
    .ctrl_wdata(ctrl_wdata), .read_status(read_status),
    .quarter_frame(quarter_frame), .half_frame(half_frame), .irq(irq),
    .step(step), .reset_pending(reset_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       qf;
    logic       hf;
    logic       irq;
    logic [2:0] step;
    logic       rp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rst_lvl  = 1'b0;

  // Reference model: position within the frame, pending-reset countdown in strobes.
  int  m_pos, m_cd, m_step;
  bit  m_five, m_inh, m_irq, m_par, m_pend, m_wrap;
  int  qpos[3] = '{S1, S2, S3};

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("quarter_frame", int'(quarter_frame), int'(e.qf));
      check("half_frame", int'(half_frame), int'(e.hf));
      check("irq", int'(irq), int'(e.irq));
      check("step", int'(step), int'(e.step));
      check("reset_pending", int'(reset_pending), int'(e.rp));
    end
  end

  function automatic void model_reset();
    m_pos = 0; m_cd = 0; m_step = 0;
    m_five = 0; m_inh = 0; m_irq = 0; m_par = 0; m_pend = 0; m_wrap = 0;
  endfunction

  function automatic exp_t model_expect(input bit en);
    exp_t e;
    int   endp;
    bit   burst, onq, onh;
    endp  = m_five ? S5E : S4E;
    burst = (m_cd == 1) && m_pend;
    onq   = (m_pos == S1) || (m_pos == S2) || (m_pos == S3) || (m_pos == endp);
    onh   = (m_pos == S2) || (m_pos == endp);
    e.qf   = en && (burst || onq);
    e.hf   = en && (burst || onh);
    e.irq  = m_irq;
    e.step = 3'(m_step);
    e.rp   = (m_cd != 0);
    return e;
  endfunction

  function automatic void model_advance(input bit wr, input bit [1:0] wd, input bit rd);
    int endp;
    bit hit, irq_on, irq_off;
    endp    = m_five ? S5E : S4E;
    hit     = (m_cd == 1);
    irq_on  = !m_five && !m_inh &&
              (m_pos == S4E - 1 || m_pos == S4E || (m_pos == 0 && m_wrap));
    irq_off = rd || m_inh || (wr && wd[0]);
    if (irq_off)     m_irq = 0;
    else if (irq_on) m_irq = 1;
    if (hit || m_pos == endp) begin
      m_step = 0;
    end else begin
      for (int i = 0; i < 3; i++) if (m_pos == qpos[i]) m_step = i + 1;
      if (m_five && m_pos == S4E) m_step = 4;
    end
    if (hit) begin
      m_pos = 0; m_wrap = 0;
    end else if (m_pos == endp) begin
      m_pos = 0; m_wrap = 1;
    end else begin
      m_pos = (m_pos + 1) % (1 << CNT_W); m_wrap = 0;
    end
    if (wr)            m_cd = m_par ? DO : DE;
    else if (m_cd > 0) m_cd = m_cd - 1;
    if (wr) begin
      m_five = wd[1]; m_inh = wd[0]; m_pend = wd[1];
    end
    m_par = !m_par;
  endfunction

  task automatic tick(input bit en, input bit wr, input bit [1:0] wd, input bit rd);
    @(posedge clk);
    #1;
    reset_n = rst_lvl; cpu_en = en; write_ctrl = wr; ctrl_wdata = wd; read_status = rd;
    if (!rst_lvl) model_reset();
    sb.push_back(model_expect(en));
    if (rst_lvl && en) model_advance(wr, wd, rd);
  endtask

  function automatic bit rand_en();
    return ($urandom_range(3) != 0);
  endfunction

  task automatic strobes(input int n);
    int done;
    bit en;
    done = 0;
    while (done < n) begin
      en = rand_en();
      tick(en, 1'b0, 2'b00, 1'b0);
      if (en) done++;
    end
  endtask

  task automatic write_on_parity(input bit par, input bit [1:0] wd);
    bit ok;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (m_par == par) begin
        tick(1'b1, 1'b1, wd, 1'b0);
        ok = 1;
      end else begin
        tick(1'b1, 1'b0, 2'b00, 1'b0);
      end
    end
    check("write_parity_reached", int'(ok), 1);
  endtask

  initial begin
    bit ok;
    bit en;
    model_reset();
    rst_lvl = 0;
    repeat (3) tick(rand_en(), 1'b0, 2'b00, 1'b0);
    rst_lvl = 1;

    // Full 4-step frame plus a little.
    strobes(S4E + 3);

    // Read status exactly on the final step with the IRQ raised.
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (m_pos == S4E && m_irq) begin
        tick(1'b1, 1'b0, 2'b00, 1'b1);
        ok = 1;
      end else begin
        en = rand_en();
        tick(en, 1'b0, 2'b00, 1'b0);
      end
    end
    check("read_at_end_reached", int'(ok), 1);
    strobes(5);

    // Even-cycle entry to 5-step mode, then a full 5-step frame.
    write_on_parity(1'b0, 2'b10);
    strobes(S5E + 5);

    // Odd-cycle write, restarted by a second write two strobes later.
    write_on_parity(1'b1, 2'b10);
    tick(1'b1, 1'b0, 2'b00, 1'b0);
    tick(1'b1, 1'b0, 2'b00, 1'b0);
    tick(1'b1, 1'b1, 2'b10, 1'b0);
    strobes(20);

    // Back to 4-step, wait for IRQ, then inhibit and run a whole frame.
    write_on_parity(1'b0, 2'b00);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (m_irq) ok = 1;
      else tick(rand_en(), 1'b0, 2'b00, 1'b0);
    end
    check("irq_raised_before_inhibit", int'(ok), 1);
    tick(1'b1, 1'b1, 2'b01, 1'b0);
    strobes(S4E + 5);

    // Asynchronous reset in the middle of a countdown.
    write_on_parity(1'b1, 2'b10);
    tick(1'b1, 1'b0, 2'b00, 1'b0);
    rst_lvl = 0;
    repeat (3) tick(rand_en(), 1'b0, 2'b00, 1'b0);
    rst_lvl = 1;
    strobes(S1 + 10);

    // Random traffic, including writes and reads without cpu_en.
    for (int i = 0; i < 1500; i++) begin
      tick(rand_en(), ($urandom_range(59) == 0), 2'($urandom_range(3)),
           ($urandom_range(39) == 0));
    end
    tick(1'b0, 1'b0, 2'b00, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
